// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and transmitter state encoding
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int FRAME_BITS = 11;
    localparam bit PAR_EVEN   = 1'b0;
    localparam bit PAR_ODD    = 1'b1;
endpackage

// File: rtl/uart_tx_hold.sv
// rtl/uart_tx_hold.sv - one-entry valid/ready holding register feeding the transmitter
module uart_tx_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_tx,
    input  logic [W-1:0] t_data,
    input  logic         t_valid,
    output logic         t_ready,
    input  logic         take,
    output logic [W-1:0] hold_data,
    output logic         hold_full
);
    assign t_ready = !hold_full && enable_tx;

    // take is only raised while full, so it never coincides with an accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (!enable_tx) begin
            hold_full <= 1'b0;
        end else if (t_valid && t_ready) begin
            hold_data <= t_data;
            hold_full <= 1'b1;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, data LSB first, parity, stop, paced by baud strobe
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = PAR_EVEN,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_uart,
    input  logic                 enable_tx,
    input  logic [DATA_BITS-1:0] t_data,
    input  logic                 t_valid,
    output logic                 t_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(DATA_BITS + 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_full;
    logic                 par_bit;
    logic [CW-1:0]        bit_cnt;
    logic [1:0]           stop_cnt;
    logic                 last_stop;
    logic                 take;

    assign last_stop = (stop_cnt == 2'(STOP_BITS - 1));
    assign take      = enable_tx && baud_uart && hold_full &&
                       ((state == IDLE) || (state == STOP && last_stop));
    assign busy      = (state != IDLE) || hold_full;

    uart_tx_hold #(.W(DATA_BITS)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .enable_tx (enable_tx),
        .t_data    (t_data),
        .t_valid   (t_valid),
        .t_ready   (t_ready),
        .take      (take),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_done  <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
        end else if (!enable_tx) begin
            state   <= IDLE;
            txd     <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (baud_uart) begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            state   <= START;
                            txd     <= 1'b0;
                            shreg   <= hold_data;
                            par_bit <= (^hold_data) ^ PARITY_ODD;
                        end
                    end
                    START: begin
                        state   <= DATA;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= CW'(1);
                    end
                    DATA: begin
                        // bit_cnt counts bits already on the line, bit0 went out from START
                        if (bit_cnt == CW'(DATA_BITS)) begin
                            state <= PARITY;
                            txd   <= par_bit;
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        stop_cnt <= '0;
                    end
                    STOP: begin
                        if (last_stop) begin
                            tx_done <= 1'b1;
                            if (hold_full) begin
                                state   <= START;
                                txd     <= 1'b0;
                                shreg   <= hold_data;
                                par_bit <= (^hold_data) ^ PARITY_ODD;
                            end else begin
                                state <= IDLE;
                                txd   <= 1'b1;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 2'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a behavioural frame receiver
module tb_uart_tx;
    logic       clk;
    logic       rst;
    logic       baud_uart;
    logic       enable_tx;
    logic [7:0] t_data;
    logic       t_valid;
    logic       t_ready, txd, busy, tx_done;
    logic       t_ready_o, txd_o, busy_o, tx_done_o;

    int total = 0;
    int bad   = 0;
    int baud_div = 16;
    int baud_cnt = 0;
    int done_cnt = 0;
    int tick_n   = 0;
    int mon_cnt  = 0;
    bit mon_en   = 1'b1;
    logic [10:0] fr, fr_odd, last_frame;
    logic        last_par, last_par_odd;
    logic [7:0]  exp_q[$];
    int          starts[$];
    int          ends[$];

    uart_tx dut (
        .clk(clk), .rst(rst), .baud_uart(baud_uart), .enable_tx(enable_tx),
        .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready),
        .txd(txd), .busy(busy), .tx_done(tx_done)
    );

    uart_tx #(.PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .baud_uart(baud_uart), .enable_tx(enable_tx),
        .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready_o),
        .txd(txd_o), .busy(busy_o), .tx_done(tx_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_uart = 1'b0;
        forever begin
            @(negedge clk);
            if (baud_cnt >= baud_div - 1) begin
                baud_uart = 1'b1;
                baud_cnt  = 0;
            end else begin
                baud_uart = 1'b0;
                baud_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame();
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            chk("rx_data", fr[8:1], e);
            chk("parity_error", ^fr[9:1], 0);
            chk("frame_error", fr[10], 1);
            chk("odd_line_data", fr_odd[8:1], e);
            chk("odd_parity_bit", fr_odd[9], ~^e);
        end
    endtask

    // Receiver model: samples the line once per baud tick, after the tick edge
    initial begin
        forever begin
            @(posedge clk);
            if (baud_uart) begin
                #1;
                tick_n++;
                if (!mon_en) begin
                    mon_cnt = 0;
                end else if (mon_cnt == 0) begin
                    if (txd == 1'b0) begin
                        fr[0]     = txd;
                        fr_odd[0] = txd_o;
                        mon_cnt   = 1;
                        starts.push_back(tick_n);
                    end
                end else begin
                    fr[mon_cnt]     = txd;
                    fr_odd[mon_cnt] = txd_o;
                    mon_cnt++;
                    if (mon_cnt == 11) begin
                        mon_cnt      = 0;
                        ends.push_back(tick_n);
                        last_frame   = fr;
                        last_par     = fr[9];
                        last_par_odd = fr_odd[9];
                        check_frame();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tx_done) done_cnt++;
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!t_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_timeout", n < 5000, 1);
        t_valid = 1'b1;
        t_data  = b;
        exp_q.push_back(b);
        @(negedge clk);
        t_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || mon_cnt != 0 || exp_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, n < 20000, 1);
    endtask

    task automatic wait_mon(input int cnt, input string tag);
        int n = 0;
        while (mon_cnt != cnt && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait_timeout"}, n < 5000, 1);
    endtask

    initial begin
        int n;
        int d0;
        rst       = 1'b1;
        enable_tx = 1'b1;
        t_valid   = 1'b0;
        t_data    = 8'h00;
        #25;
        chk("reset_txd", txd, 1);
        chk("reset_t_ready", t_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_tx_done", tx_done, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: 0xA5 at 16 clocks per bit
        done_cnt = 0;
        send(8'hA5);
        n = 0;
        while (!tx_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("a5_tx_done_seen", tx_done, 1);
        chk("a5_busy_with_done", busy, 0);
        @(negedge clk);
        chk("a5_tx_done_one_clk", tx_done, 0);
        chk("a5_done_count", done_cnt, 1);
        chk("a5_frame_bits", last_frame, {1'b1, 1'b0, 8'hA5, 1'b0});

        // 2: odd popcount byte
        send(8'h01);
        wait_idle("b01");
        chk("b01_even_parity_bit", last_par, 1);
        chk("b01_odd_parity_bit", last_par_odd, 0);

        // 3: back-to-back with t_valid held high
        baud_div = 4;
        starts.delete();
        ends.delete();
        @(negedge clk);
        t_valid = 1'b1;
        t_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        t_data = 8'hC3;
        exp_q.push_back(8'hC3);
        n = 0;
        while (!t_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_ready", t_ready, 1);
        @(negedge clk);
        chk("b2b_ready_drops", t_ready, 0);
        t_valid = 1'b0;
        wait_idle("b2b");
        chk("b2b_frame_count", starts.size(), 2);
        chk("b2b_no_idle_bit",
            (starts.size() == 2 && ends.size() == 2) ? starts[1] - ends[0] : -1, 1);
        chk("b2b_total_ticks",
            (starts.size() == 2 && ends.size() == 2) ? ends[1] - starts[0] + 1 : -1, 22);

        // 4: loopback patterns with baud held high
        baud_div = 1;
        ends.delete();
        send(8'h00);
        send(8'hFF);
        send(8'h55);
        wait_idle("loop");
        chk("loop_frame_count", ends.size(), 3);

        // 5: abort during DATA bit 3, then a clean frame
        baud_div = 16;
        send(8'h96);
        wait_mon(5, "abort");
        @(negedge clk);
        @(negedge clk);
        enable_tx = 1'b0;
        mon_en    = 1'b0;
        void'(exp_q.pop_back());
        d0 = done_cnt;
        @(posedge clk);
        #1;
        chk("abort_txd", txd, 1);
        chk("abort_busy", busy, 0);
        chk("abort_t_ready", t_ready, 0);
        chk("abort_tx_done", tx_done, 0);
        repeat (20) @(negedge clk);
        chk("abort_t_ready_held", t_ready, 0);
        chk("abort_no_done", done_cnt, d0);
        enable_tx = 1'b1;
        mon_en    = 1'b1;
        send(8'h7E);
        wait_idle("reenable");
        chk("reenable_frame", last_frame, {1'b1, 1'b0, 8'h7E, 1'b0});

        // 6: asynchronous reset in the PARITY bit
        send(8'h5A);
        wait_mon(10, "rst");
        repeat (3) @(negedge clk);
        #2;
        d0 = done_cnt;
        rst    = 1'b1;
        mon_en = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx_done", tx_done, 0);
        repeat (20) @(negedge clk);
        chk("rst_no_done", done_cnt, d0);
        rst = 1'b0;
        #1;
        chk("rst_release_t_ready", t_ready, 1);
        mon_en = 1'b1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
